alu_cmd_sequencer: RTL and testbench

//   Sequencing stage that feeds the 4-bit combinational alu. Accepts ALU commands over a

---
 rtl/alu_cmd_sequencer.sv | 269 ++++++++++++++++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// alu_cmd_sequencer
//   Sequencing stage in front of the 4-bit combinational alu. Commands enter
//   through a valid/ready handshake into a small FIFO. One command per cycle
//   is issued to the alu, and a 4-bit accumulator supports chained operations.
//   Each result and its flags are registered and offered downstream through a
//   second valid/ready handshake.
//
// Parameters
//   FIFO_DEPTH  command FIFO entries (power of two, >= 2)
//   ACC_INIT    accumulator value after reset and after clear_acc
//
// Ports
//   clk, rst_n                    clock, synchronous active-low reset
//   cmd_valid/cmd_ready           command handshake (cmd_ready = !fifo_full)
//   cmd_op, cmd_use_acc, cmd_a,   alu select, x-source select, x operand,
//   cmd_b, cmd_wb                 y operand, accumulator writeback enable
//   clear_acc                     pulse: accumulator <= ACC_INIT
//   res_valid/res_ready           result handshake
//   res_data, res_c, res_zero,    registered alu outputs
//   res_ovf
//   acc                           current accumulator
//   busy                          FIFO non-empty or result pending
//   sticky_ovf                    only with ALU_SEQ_STICKY_OVF_EN: set by any
//                                 issued overflow, cleared by reset/clear_acc
//
// Build option: define ALU_SEQ_STICKY_OVF_EN to add the sticky_ovf output.
// ---------------------------------------------------------------------------

// 4-bit combinational alu.
//   000 add  001 sub  010 and  011 or  100 xor  101 not-x
//   110 signed less-than  111 equal
// The adder computes x + (y or ~y) + in_c; sub/lt/eq invert y. zero reflects
// the adder result for arithmetic/compare ops and out_s for logic ops.
module alu (
  input  logic [3:0] in_x,
  input  logic [3:0] in_y,
  input  logic       in_c,
  input  logic [2:0] sel,
  output logic [3:0] out_s,
  output logic       out_c,
  output logic       zero,
  output logic       overflow
);
  logic [3:0] w_yop;
  logic [3:0] w_sum;
  logic       w_cout;
  logic       w_ov;
  logic       w_inv;

  assign w_inv = (sel == 3'b001) || (sel == 3'b110) || (sel == 3'b111);
  assign w_yop = w_inv ? ~in_y : in_y;
  assign {w_cout, w_sum} = {1'b0, in_x} + {1'b0, w_yop} + {4'b0000, in_c};
  assign w_ov = (in_x[3] == w_yop[3]) && (w_sum[3] != in_x[3]);

  always_comb begin
    out_s    = '0;
    out_c    = 1'b0;
    zero     = 1'b0;
    overflow = 1'b0;
    case (sel)
      3'b000, 3'b001: begin
        out_s    = w_sum;
        out_c    = w_cout;
        zero     = (w_sum == 4'h0);
        overflow = w_ov;
      end
      3'b010: begin out_s = in_x & in_y; zero = ((in_x & in_y) == 4'h0); end
      3'b011: begin out_s = in_x | in_y; zero = ((in_x | in_y) == 4'h0); end
      3'b100: begin out_s = in_x ^ in_y; zero = ((in_x ^ in_y) == 4'h0); end
      3'b101: begin out_s = ~in_x;       zero = (in_x == 4'hF);          end
      3'b110: begin
        // signed x < y: sign of difference corrected by overflow
        out_s = {3'b000, w_sum[3] ^ w_ov};
        out_c = w_cout;
        zero  = (w_sum == 4'h0);
      end
      default: begin
        out_s = {3'b000, w_sum == 4'h0};
        out_c = w_cout;
        zero  = (w_sum == 4'h0);
      end
    endcase
  end
endmodule

module alu_cmd_sequencer #(
  parameter int unsigned FIFO_DEPTH = 2,
  parameter logic [3:0]  ACC_INIT   = 4'h0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_op,
  input  logic       cmd_use_acc,
  input  logic [3:0] cmd_a,
  input  logic [3:0] cmd_b,
  input  logic       cmd_wb,
  input  logic       clear_acc,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [3:0] res_data,
  output logic       res_c,
  output logic       res_zero,
  output logic       res_ovf,
  output logic [3:0] acc,
  output logic       busy
`ifdef ALU_SEQ_STICKY_OVF_EN
  ,
  output logic       sticky_ovf
`endif
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic [2:0] op;
    logic       use_acc;
    logic [3:0] a;
    logic [3:0] b;
    logic       wb;
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2
  } state_t;

  cmd_t        r_mem [FIFO_DEPTH];
  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  state_t      r_state;
  logic [3:0]  r_acc;
  logic        r_res_valid;
  logic [3:0]  r_res_data;
  logic        r_res_c;
  logic        r_res_zero;
  logic        r_res_ovf;

  logic        w_empty;
  logic        w_full;
  logic        w_push;
  logic        w_issue;
  cmd_t        w_head;
  logic [3:0]  w_x;
  logic        w_cin;
  logic [3:0]  w_s;
  logic        w_c;
  logic        w_zero;
  logic        w_ovf;
  logic [AW:0] w_wr_nxt;
  logic [AW:0] w_rd_nxt;
  logic        w_nonempty_nxt;
  logic        w_res_valid_nxt;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_push  = cmd_valid & ~w_full;
  assign w_issue = ~w_empty & (~r_res_valid | res_ready);

  assign w_head = r_mem[r_rd_ptr[AW-1:0]];
  assign w_x    = w_head.use_acc ? r_acc : w_head.a;
  assign w_cin  = (w_head.op == 3'b001) || (w_head.op == 3'b110) ||
                  (w_head.op == 3'b111);

  alu u_alu (
    .in_x    (w_x),
    .in_y    (w_head.b),
    .in_c    (w_cin),
    .sel     (w_head.op),
    .out_s   (w_s),
    .out_c   (w_c),
    .zero    (w_zero),
    .overflow(w_ovf)
  );

  assign w_wr_nxt        = r_wr_ptr + {{AW{1'b0}}, w_push};
  assign w_rd_nxt        = r_rd_ptr + {{AW{1'b0}}, w_issue};
  assign w_nonempty_nxt  = (w_wr_nxt != w_rd_nxt);
  assign w_res_valid_nxt = w_issue | (r_res_valid & ~res_ready);

  // Storage is not reset; the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= '{op: cmd_op, use_acc: cmd_use_acc,
                                   a: cmd_a, b: cmd_b, wb: cmd_wb};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_state     <= IDLE;
      r_acc       <= ACC_INIT;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_res_c     <= 1'b0;
      r_res_zero  <= 1'b0;
      r_res_ovf   <= 1'b0;
    end else begin
      r_wr_ptr <= w_wr_nxt;
      r_rd_ptr <= w_rd_nxt;

      // Issued command sees the accumulator as of this edge, so a writeback
      // is visible to the very next issue. clear_acc overrides writeback.
      if (clear_acc) begin
        r_acc <= ACC_INIT;
      end else if (w_issue && w_head.wb) begin
        r_acc <= w_s;
      end

      if (w_issue) begin
        r_res_valid <= 1'b1;
        r_res_data  <= w_s;
        r_res_c     <= w_c;
        r_res_zero  <= w_zero;
        r_res_ovf   <= w_ovf;
      end else if (res_ready) begin
        r_res_valid <= 1'b0;
      end

      // busy is derived from state, so every transition tracks the next
      // FIFO occupancy and result-pending status exactly.
      case (r_state)
        IDLE: begin
          if (w_push) r_state <= RUN;
        end
        RUN: begin
          if (!w_nonempty_nxt && !w_res_valid_nxt) begin
            r_state <= IDLE;
          end else if (r_res_valid && !res_ready && !w_empty) begin
            r_state <= STALL;
          end
        end
        STALL: begin
          if (res_ready) r_state <= RUN;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef ALU_SEQ_STICKY_OVF_EN
  logic r_sticky_ovf;

  always_ff @(posedge clk) begin
    if (!rst_n || clear_acc) begin
      r_sticky_ovf <= 1'b0;
    end else if (w_issue && w_ovf) begin
      r_sticky_ovf <= 1'b1;
    end
  end

  assign sticky_ovf = r_sticky_ovf;
`endif

  assign cmd_ready = ~w_full;
  assign res_valid = r_res_valid;
  assign res_data  = r_res_data;
  assign res_c     = r_res_c;
  assign res_zero  = r_res_zero;
  assign res_ovf   = r_res_ovf;
  assign acc       = r_acc;
  assign busy      = (r_state != IDLE);
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
module tb_alu_cmd_sequencer;
  localparam int unsigned DEPTH = 2;
  localparam logic [3:0]  INIT  = 4'h0;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic       cmd_use_acc;
  logic [3:0] cmd_a;
  logic [3:0] cmd_b;
  logic       cmd_wb;
  logic       clear_acc;
  logic       res_valid;
  logic       res_ready;
  logic [3:0] res_data;
  logic       res_c;
  logic       res_zero;
  logic       res_ovf;
  logic [3:0] acc;
  logic       busy;
`ifdef ALU_SEQ_STICKY_OVF_EN
  logic       sticky_ovf;
`endif

  alu_cmd_sequencer #(
    .FIFO_DEPTH(DEPTH),
    .ACC_INIT  (INIT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_use_acc(cmd_use_acc),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .cmd_wb     (cmd_wb),
    .clear_acc  (clear_acc),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_c      (res_c),
    .res_zero   (res_zero),
    .res_ovf    (res_ovf),
    .acc        (acc),
    .busy       (busy)
`ifdef ALU_SEQ_STICKY_OVF_EN
    ,
    .sticky_ovf (sticky_ovf)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int rx_cnt = 0;
  int rx_last_cyc = 0;
  int rx_prev_cyc = 0;
  logic [3:0] m_acc;
  logic [6:0] exp_q[$];

  typedef struct {
    logic [2:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] s;
    logic       c;
    logic       z;
    logic       o;
  } vec_t;
  vec_t vecs[13];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference alu written in integer arithmetic; packs {s, c, zero, ovf}.
  function automatic logic [6:0] model(input logic [2:0] op, input logic [3:0] x,
                                       input logic [3:0] y);
    int sx, sy, r;
    logic [3:0] s;
    logic c, z, o;
    sx = (x > 4'd7) ? int'(x) - 16 : int'(x);
    sy = (y > 4'd7) ? int'(y) - 16 : int'(y);
    c = 1'b0; o = 1'b0; s = 4'h0; z = 1'b0;
    case (op)
      3'd0: begin
        r = int'(x) + int'(y); s = r[3:0]; c = (r > 15);
        o = ((sx + sy) > 7) || ((sx + sy) < -8); z = (s == 4'h0);
      end
      3'd1: begin
        r = int'(x) - int'(y); s = r[3:0]; c = (x >= y);
        o = ((sx - sy) > 7) || ((sx - sy) < -8); z = (s == 4'h0);
      end
      3'd2: begin s = x & y; z = (s == 4'h0); end
      3'd3: begin s = x | y; z = (s == 4'h0); end
      3'd4: begin s = x ^ y; z = (s == 4'h0); end
      3'd5: begin s = ~x;    z = (s == 4'h0); end
      3'd6: begin s = {3'b000, sx < sy}; c = (x >= y); z = (x == y); end
      default: begin s = {3'b000, x == y}; c = (x >= y); z = (x == y); end
    endcase
    return {s, c, z, o};
  endfunction

  always @(posedge clk) cyc++;

  // Scoreboard consumer: compares every accepted result in order.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", {res_data, res_c, res_zero, res_ovf}, 999);
      end else begin
        chk("result", int'({res_data, res_c, res_zero, res_ovf}), int'(exp_q.pop_front()));
      end
      rx_prev_cyc = rx_last_cyc;
      rx_last_cyc = cyc;
      rx_cnt++;
    end
  end

  // Offers one command and returns #1 after the edge it was accepted on.
  // cmd_valid stays high so consecutive calls push back-to-back.
  task automatic push_cmd(input logic [2:0] op, input logic ua, input logic [3:0] a,
                          input logic [3:0] b, input logic wb, input logic [6:0] exp);
    int w;
    cmd_valid = 1'b1; cmd_op = op; cmd_use_acc = ua; cmd_a = a; cmd_b = b; cmd_wb = wb;
    w = 0;
    @(negedge clk);
    while (!cmd_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!cmd_ready) begin
      chk("push_timeout", 0, 1);
    end else begin
      @(posedge clk);
      exp_q.push_back(exp);
      #1;
    end
  endtask

  task automatic push_m(input logic [2:0] op, input logic ua, input logic [3:0] a,
                        input logic [3:0] b, input logic wb);
    logic [6:0] e;
    e = model(op, ua ? m_acc : a, b);
    if (wb) m_acc = e[6:3];
    push_cmd(op, ua, a, b, wb, e);
  endtask

  task automatic wait_drain();
    int w;
    w = 0;
    while ((exp_q.size() != 0 || busy) && w < 200) begin
      @(negedge clk);
      w++;
    end
    chk("drain_timeout", int'(exp_q.size() == 0 && !busy), 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int rx0;
    vecs[0]  = '{3'd0, 4'h3, 4'h4, 4'h7, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{3'd0, 4'h7, 4'h1, 4'h8, 1'b0, 1'b0, 1'b1};
    vecs[2]  = '{3'd0, 4'hF, 4'h1, 4'h0, 1'b1, 1'b1, 1'b0};
    vecs[3]  = '{3'd1, 4'h8, 4'h1, 4'h7, 1'b1, 1'b0, 1'b1};
    vecs[4]  = '{3'd1, 4'h3, 4'h5, 4'hE, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{3'd2, 4'hC, 4'hA, 4'h8, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{3'd3, 4'h5, 4'hA, 4'hF, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{3'd4, 4'h6, 4'h6, 4'h0, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{3'd5, 4'h3, 4'h0, 4'hC, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{3'd6, 4'h2, 4'h7, 4'h1, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{3'd6, 4'h8, 4'h1, 4'h1, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{3'd7, 4'h5, 4'h5, 4'h1, 1'b1, 1'b1, 1'b0};
    vecs[12] = '{3'd7, 4'h5, 4'h6, 4'h0, 1'b0, 1'b0, 1'b0};

    // Reset held two cycles while a command is offered.
    rst_n = 1'b0; cmd_valid = 1'b1; cmd_op = 3'd0; cmd_use_acc = 1'b0;
    cmd_a = 4'h1; cmd_b = 4'h1; cmd_wb = 1'b1; clear_acc = 1'b0; res_ready = 1'b1;
    m_acc = INIT;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_acc", acc, INIT);
    chk("reset_res_valid", res_valid, 0);
    chk("reset_cmd_ready", cmd_ready, 1);
    chk("reset_busy", busy, 0);
    chk("reset_res_data", res_data, 0);
`ifdef ALU_SEQ_STICKY_OVF_EN
    chk("reset_sticky", sticky_ovf, 0);
`endif
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    rst_n = 1'b1;

    // Table of single operations, pushed back-to-back.
    for (int i = 0; i < 13; i++) begin
      push_cmd(vecs[i].op, 1'b0, vecs[i].a, vecs[i].b, 1'b0,
               {vecs[i].s, vecs[i].c, vecs[i].z, vecs[i].o});
    end
    cmd_valid = 1'b0;
    wait_drain();
`ifdef ALU_SEQ_STICKY_OVF_EN
    chk("sticky_set", sticky_ovf, 1);
`endif

    // Accumulator chain: 3+4 -> acc, acc+2 -> acc.
    push_m(3'd0, 1'b0, 4'h3, 4'h4, 1'b1);
    push_m(3'd0, 1'b1, 4'h0, 4'h2, 1'b1);
    cmd_valid = 1'b0;
    wait_drain();
    chk("chain_acc", acc, 9);
    chk("chain_consecutive", rx_last_cyc - rx_prev_cyc, 1);

    // Backpressure: DEPTH+1 commands with the consumer stalled.
    res_ready = 1'b0;
    rx0 = rx_cnt;
    push_m(3'd0, 1'b0, 4'h1, 4'h1, 1'b0);
    push_m(3'd0, 1'b0, 4'h2, 4'h2, 1'b0);
    push_m(3'd0, 1'b0, 4'h3, 4'h3, 1'b0);
    cmd_op = 3'd0; cmd_a = 4'h4; cmd_b = 4'h4;  // extra offer, must be refused
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_cmd_ready", cmd_ready, 0);
      chk("bp_res_valid", res_valid, 1);
      chk("bp_res_frozen", {res_data, res_c, res_zero, res_ovf}, 7'b0010_000);
      chk("bp_busy", busy, 1);
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    wait_drain();
    chk("bp_count", rx_cnt - rx0, 3);

    // Clear on the same edge as a writeback issue producing 5.
    push_m(3'd0, 1'b0, 4'h2, 4'h3, 1'b1);
    cmd_valid = 1'b0;
    clear_acc = 1'b1;
    @(posedge clk);
    #1;
    clear_acc = 1'b0;
    m_acc = INIT;
    @(negedge clk);
    chk("collision_acc", acc, INIT);
`ifdef ALU_SEQ_STICKY_OVF_EN
    chk("collision_sticky", sticky_ovf, 0);
`endif
    wait_drain();
    push_m(3'd0, 1'b1, 4'h0, 4'h1, 1'b0);
    cmd_valid = 1'b0;
    wait_drain();

    // Random commands with a randomly stalling consumer.
    fork
      begin
        repeat (60) begin
          @(posedge clk);
          #1;
          res_ready = 1'($urandom_range(0, 1));
        end
      end
      begin
        for (int n = 0; n < 16; n++) begin
          push_m(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                 1'($urandom_range(0, 1)));
        end
        cmd_valid = 1'b0;
      end
    join
    res_ready = 1'b1;
    wait_drain();
    chk("random_acc", acc, m_acc);

    // Reset while the FIFO is full and the result is stalled.
    res_ready = 1'b0;
    push_m(3'd0, 1'b0, 4'h7, 4'h1, 1'b1);
    push_m(3'd1, 1'b0, 4'h8, 4'h1, 1'b0);
    push_m(3'd2, 1'b0, 4'hF, 4'h3, 1'b0);
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("pre_reset_full", cmd_ready, 0);
    chk("pre_reset_acc", acc, 8);
`ifdef ALU_SEQ_STICKY_OVF_EN
    chk("pre_reset_sticky", sticky_ovf, 1);
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
    m_acc = INIT;
    @(negedge clk);
    chk("midreset_cmd_ready", cmd_ready, 1);
    chk("midreset_res_valid", res_valid, 0);
    chk("midreset_busy", busy, 0);
    chk("midreset_acc", acc, INIT);
    chk("midreset_res_data", res_data, 0);
`ifdef ALU_SEQ_STICKY_OVF_EN
    chk("midreset_sticky", sticky_ovf, 0);
`endif
    @(posedge clk);
    #1;
    res_ready = 1'b1;
    push_m(3'd7, 1'b0, 4'h9, 4'h9, 1'b0);
    cmd_valid = 1'b0;
    wait_drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
